exception_unit: RTL and testbench
=================================

# exception_unit

Collects exception reports from fetch, decode and memory and selects the oldest one in program order. It issues a single registered exception event to the privileged register file, which saves the fault PC, address and info, sets supervisor mode and redirects to the handler. It also flushes the younger pipeline stages for a fixed drain window. User-mode writes to the rm registers are also detected here as privilege violations.

## Interface
Parameters:
- FLUSH_CYCLES, 3, cycles the flush outputs stay asserted after an exception is taken (≥1).

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- in_if_itlb_miss  in  1  fetch: iTLB miss on a valid fetch
- in_if_pc  in  32  fetch PC
- in_id_illegal  in  1  decode: illegal opcode on a valid instruction
- in_id_pc  in  32  decode PC
- in_id_instr  in  32  decode instruction word
- in_id_rm_write  in  1  decode: valid mov-to-rm instruction (includes iret)
- in_id_rm_idx  in  3  target rm index
- in_mem_dtlb_miss  in  1  memory: dTLB miss on a valid load/store
- in_mem_misaligned  in  1  memory: misaligned access
- in_mem_is_store  in  1  memory op is a store
- in_mem_pc  in  32  memory-stage PC
- in_mem_addr  in  32  memory effective address
- in_supervisor_mode  in  1  current mode from the privileged register file
- out_exception_vector  out  3  code of the taken exception, one-cycle pulse; 0 = none
- out_fault_pc  out  32  PC of the faulting instruction
- out_fault_addr  out  32  faulting address
- out_additional_info  out  32  cause-specific info
- out_flush_if  out  1  squash fetch
- out_flush_id  out  1  squash decode
- out_flush_ex  out  1  squash execute
- out_busy  out  1  high while in FLUSH

## Operation
Exception codes, highest priority first (older stage wins):
- 3'd3 dtlb_miss. Fault address is in_mem_addr. Info is {31'b0, in_mem_is_store}.
- 3'd4 misaligned. Fault address is in_mem_addr. Info is {31'b0, in_mem_is_store}.
- 3'd2 illegal. Fault address is 0. Info is in_id_instr.
- 3'd5 privilege. Raised when in_id_rm_write is high and in_supervisor_mode is low. Fault address is 0. Info is {29'b0, in_id_rm_idx}.
- 3'd1 itlb_miss. Fault address is in_if_pc. Info is 0.

Rules:
- Fault PC is the PC of the reporting stage.
- Within the memory stage, dtlb_miss beats misaligned.
- Within decode, illegal beats privilege.
- All lower-priority reports in the same cycle are discarded; those instructions are squashed anyway.

State machine:
- IDLE: any report moves to FLUSH, loads the flush counter with FLUSH_CYCLES and latches all outputs.
- FLUSH: all inputs are ignored. The counter decrements each cycle; when it reaches 1 the next state is IDLE.
- Flush scope:
  - A memory-stage cause asserts out_flush_if, out_flush_id and out_flush_ex.
  - A decode cause asserts out_flush_if and out_flush_id.
  - A fetch cause asserts out_flush_if only.
- A supervisor-mode rm write is not an exception and produces no output.

## Timing
- Reset values: every output is 0, state is IDLE, the counter is 0. Reset takes priority over all inputs.
- Reports are sampled at the rising edge ending cycle N.
- out_exception_vector and the fault fields are valid in cycle N+1 only. They return to 0 in N+2.
- Flush outputs and out_busy are high for exactly cycles N+1 .. N+FLUSH_CYCLES.
- Earliest next accepted report is cycle N+FLUSH_CYCLES. If it is accepted, its outputs appear in N+FLUSH_CYCLES+1, giving back-to-back windows with no gap.
- Reset asserted mid-FLUSH: the next cycle returns to IDLE with all outputs at 0. No partial pulse may remain.
- All outputs are registered; there is no combinational input-to-output path.

## Structure
- Shared package priv_pkg holds:
  - the exc_code_t 3-bit enum (NONE=0, ITLB=1, ILLEGAL=2, DTLB=3, MISALIGNED=4, PRIV=5);
  - the HANDLER_ADDR constant 32'h2000;
  - RM_COUNT = 5.
- The privileged register file and this block both import priv_pkg.
- One sub-module, exc_priority_sel: a combinational priority encoder that produces the code, fault PC, fault address, info and flush mask. The FSM, counter and output registers remain in exception_unit.

## Test plan
- Single memory fault: in_mem_dtlb_miss=1, in_mem_pc=0x40, in_mem_addr=0x8004, in_mem_is_store=1.
  - Next cycle: vector=3, fault_pc=0x40, fault_addr=0x8004, info=1.
  - All three flushes high for 3 cycles; busy for 3 cycles.
- Simultaneous reports: itlb (pc=0x50), illegal (pc=0x4C) and misaligned (pc=0x48, addr=0x9001) in the same cycle.
  - Vector=4, fault_pc=0x48, fault_addr=0x9001.
  - No later pulse for the younger reports.
- Privilege check:
  - rm_write with idx=4 and supervisor=0 -> vector=5, info=4, flush_if and flush_id only.
  - The same input with supervisor=1 -> no output activity.
- Ignore during FLUSH: an illegal report in N+2 is dropped. An illegal report (instr=0xFFFFFFFF) in N+3 pulses vector=2 in N+4 with info=0xFFFFFFFF.
- Reset mid-FLUSH: reset asserted in N+2 -> all outputs 0 in N+3, busy=0; the next report is accepted normally.
- Parameter FLUSH_CYCLES=1: two consecutive-cycle itlb reports produce two one-cycle pulses on consecutive cycles.

Source files
------------

// File: rtl/priv_pkg.sv
// Shared privileged-architecture definitions: exception codes, handler
// entry point and the number of rm registers.
package priv_pkg;

    // Exception cause codes; NONE means no exception this cycle.
    typedef enum logic [2:0] {
        NONE       = 3'd0,
        ITLB       = 3'd1,
        ILLEGAL    = 3'd2,
        DTLB       = 3'd3,
        MISALIGNED = 3'd4,
        PRIV       = 3'd5
    } exc_code_t;

    localparam logic [31:0] HANDLER_ADDR = 32'h2000;
    localparam int unsigned RM_COUNT     = 5;

    // Flush masks, bit order {ex, id, if}: an older stage squashes everything younger.
    localparam logic [2:0] FLUSH_MEM = 3'b111;
    localparam logic [2:0] FLUSH_DEC = 3'b011;
    localparam logic [2:0] FLUSH_FET = 3'b001;

endpackage

// File: rtl/exc_priority_sel.sv
// Combinational priority encoder: picks the oldest exception report in
// program order (memory, then decode, then fetch) and forms its record.
module exc_priority_sel
    import priv_pkg::*;
(
    input  logic        in_if_itlb_miss,
    input  logic [31:0] in_if_pc,
    input  logic        in_id_illegal,
    input  logic [31:0] in_id_pc,
    input  logic [31:0] in_id_instr,
    input  logic        in_id_rm_write,
    input  logic [2:0]  in_id_rm_idx,
    input  logic        in_mem_dtlb_miss,
    input  logic        in_mem_misaligned,
    input  logic        in_mem_is_store,
    input  logic [31:0] in_mem_pc,
    input  logic [31:0] in_mem_addr,
    input  logic        in_supervisor_mode,
    output logic        out_valid,
    output exc_code_t   out_code,
    output logic [31:0] out_fault_pc,
    output logic [31:0] out_fault_addr,
    output logic [31:0] out_info,
    output logic [2:0]  out_flush_mask
);

    logic w_priv_viol;

    // A supervisor-mode rm write is legal and never reaches the selector.
    assign w_priv_viol = in_id_rm_write && !in_supervisor_mode;

    // Priority chain, oldest stage first; younger reports are dropped.
    always_comb begin
        out_valid      = 1'b1;
        out_code       = NONE;
        out_fault_pc   = '0;
        out_fault_addr = '0;
        out_info       = '0;
        out_flush_mask = '0;
        if (in_mem_dtlb_miss) begin
            out_code       = DTLB;
            out_fault_pc   = in_mem_pc;
            out_fault_addr = in_mem_addr;
            out_info       = {31'b0, in_mem_is_store};
            out_flush_mask = FLUSH_MEM;
        end else if (in_mem_misaligned) begin
            out_code       = MISALIGNED;
            out_fault_pc   = in_mem_pc;
            out_fault_addr = in_mem_addr;
            out_info       = {31'b0, in_mem_is_store};
            out_flush_mask = FLUSH_MEM;
        end else if (in_id_illegal) begin
            out_code       = ILLEGAL;
            out_fault_pc   = in_id_pc;
            out_info       = in_id_instr;
            out_flush_mask = FLUSH_DEC;
        end else if (w_priv_viol) begin
            out_code       = PRIV;
            out_fault_pc   = in_id_pc;
            out_info       = {29'b0, in_id_rm_idx};
            out_flush_mask = FLUSH_DEC;
        end else if (in_if_itlb_miss) begin
            out_code       = ITLB;
            out_fault_pc   = in_if_pc;
            out_fault_addr = in_if_pc;
            out_flush_mask = FLUSH_FET;
        end else begin
            out_valid      = 1'b0;
        end
    end

endmodule

// File: rtl/exception_unit.sv
// Exception unit: registers the highest-priority exception as a one-cycle
// event and holds the matching pipeline flushes for FLUSH_CYCLES cycles.
module exception_unit
    import priv_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_if_itlb_miss,
    input  logic [31:0] in_if_pc,
    input  logic        in_id_illegal,
    input  logic [31:0] in_id_pc,
    input  logic [31:0] in_id_instr,
    input  logic        in_id_rm_write,
    input  logic [2:0]  in_id_rm_idx,
    input  logic        in_mem_dtlb_miss,
    input  logic        in_mem_misaligned,
    input  logic        in_mem_is_store,
    input  logic [31:0] in_mem_pc,
    input  logic [31:0] in_mem_addr,
    input  logic        in_supervisor_mode,
    output logic [2:0]  out_exception_vector,
    output logic [31:0] out_fault_pc,
    output logic [31:0] out_fault_addr,
    output logic [31:0] out_additional_info,
    output logic        out_flush_if,
    output logic        out_flush_id,
    output logic        out_flush_ex,
    output logic        out_busy
);

    localparam int unsigned CNT_W = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES + 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t             r_state,      w_state_nxt;
    logic [CNT_W-1:0]   r_count,      w_count_nxt;
    exc_code_t          r_vec,        w_vec_nxt;
    logic [31:0]        r_fault_pc,   w_fault_pc_nxt;
    logic [31:0]        r_fault_addr, w_fault_addr_nxt;
    logic [31:0]        r_info,       w_info_nxt;
    logic [2:0]         r_flush,      w_flush_nxt;

    logic               w_sel_valid;
    exc_code_t          w_sel_code;
    logic [31:0]        w_sel_pc;
    logic [31:0]        w_sel_addr;
    logic [31:0]        w_sel_info;
    logic [2:0]         w_sel_mask;
    logic               w_accept;

    exc_priority_sel u_sel (
        .in_if_itlb_miss    (in_if_itlb_miss),
        .in_if_pc           (in_if_pc),
        .in_id_illegal      (in_id_illegal),
        .in_id_pc           (in_id_pc),
        .in_id_instr        (in_id_instr),
        .in_id_rm_write     (in_id_rm_write),
        .in_id_rm_idx       (in_id_rm_idx),
        .in_mem_dtlb_miss   (in_mem_dtlb_miss),
        .in_mem_misaligned  (in_mem_misaligned),
        .in_mem_is_store    (in_mem_is_store),
        .in_mem_pc          (in_mem_pc),
        .in_mem_addr        (in_mem_addr),
        .in_supervisor_mode (in_supervisor_mode),
        .out_valid          (w_sel_valid),
        .out_code           (w_sel_code),
        .out_fault_pc       (w_sel_pc),
        .out_fault_addr     (w_sel_addr),
        .out_info           (w_sel_info),
        .out_flush_mask     (w_sel_mask)
    );

    // The last FLUSH cycle already accepts a new report so windows can abut.
    assign w_accept = (r_state == ST_IDLE) || (r_count == CNT_W'(1));

    // Next-state logic: take a report, keep draining, or fall back to idle.
    always_comb begin
        w_state_nxt      = ST_IDLE;
        w_count_nxt      = '0;
        w_vec_nxt        = NONE;
        w_fault_pc_nxt   = '0;
        w_fault_addr_nxt = '0;
        w_info_nxt       = '0;
        w_flush_nxt      = '0;
        if (w_accept && w_sel_valid) begin
            w_state_nxt      = ST_FLUSH;
            w_count_nxt      = CNT_W'(FLUSH_CYCLES);
            w_vec_nxt        = w_sel_code;
            w_fault_pc_nxt   = w_sel_pc;
            w_fault_addr_nxt = w_sel_addr;
            w_info_nxt       = w_sel_info;
            w_flush_nxt      = w_sel_mask;
        end else if (!w_accept) begin
            w_state_nxt      = ST_FLUSH;
            w_count_nxt      = r_count - CNT_W'(1);
            w_flush_nxt      = r_flush;
        end
    end

    // State, counter and output registers; reset clears everything at once.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_count      <= '0;
            r_vec        <= NONE;
            r_fault_pc   <= '0;
            r_fault_addr <= '0;
            r_info       <= '0;
            r_flush      <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_count      <= w_count_nxt;
            r_vec        <= w_vec_nxt;
            r_fault_pc   <= w_fault_pc_nxt;
            r_fault_addr <= w_fault_addr_nxt;
            r_info       <= w_info_nxt;
            r_flush      <= w_flush_nxt;
        end
    end

    assign out_exception_vector = r_vec;
    assign out_fault_pc         = r_fault_pc;
    assign out_fault_addr       = r_fault_addr;
    assign out_additional_info  = r_info;
    assign out_flush_if         = r_flush[0];
    assign out_flush_id         = r_flush[1];
    assign out_flush_ex         = r_flush[2];
    assign out_busy             = (r_state == ST_FLUSH);

endmodule

// File: tb/tb_exception_unit.sv
// Scoreboard bench for exception_unit (FLUSH_CYCLES=3) plus a directed
// check of back-to-back windows on a FLUSH_CYCLES=1 instance.
module tb_exception_unit;

    localparam int FC = 3;

    typedef struct packed {
        logic [2:0]  vec;
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] info;
        logic [2:0]  fl;   // {ex, id, if}
        logic        busy;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        itlb, illegal, rm_write, dtlb, misal, is_store, sup;
    logic [31:0] if_pc, id_pc, id_instr, mem_pc, mem_addr;
    logic [2:0]  rm_idx;

    logic [2:0]  o_vec;
    logic [31:0] o_pc, o_addr, o_info;
    logic        o_fif, o_fid, o_fex, o_busy;

    logic        itlb2;
    logic [31:0] if_pc2;
    logic [2:0]  o2_vec;
    logic [31:0] o2_pc, o2_addr, o2_info;
    logic        o2_fif, o2_fid, o2_fex, o2_busy;

    exp_t q[$];
    int   m_left;
    logic [2:0] m_mask;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    exception_unit #(.FLUSH_CYCLES(FC)) dut (
        .clk(clk), .reset(reset),
        .in_if_itlb_miss(itlb), .in_if_pc(if_pc),
        .in_id_illegal(illegal), .in_id_pc(id_pc), .in_id_instr(id_instr),
        .in_id_rm_write(rm_write), .in_id_rm_idx(rm_idx),
        .in_mem_dtlb_miss(dtlb), .in_mem_misaligned(misal),
        .in_mem_is_store(is_store), .in_mem_pc(mem_pc), .in_mem_addr(mem_addr),
        .in_supervisor_mode(sup),
        .out_exception_vector(o_vec), .out_fault_pc(o_pc),
        .out_fault_addr(o_addr), .out_additional_info(o_info),
        .out_flush_if(o_fif), .out_flush_id(o_fid), .out_flush_ex(o_fex),
        .out_busy(o_busy)
    );

    exception_unit #(.FLUSH_CYCLES(1)) dut1 (
        .clk(clk), .reset(reset),
        .in_if_itlb_miss(itlb2), .in_if_pc(if_pc2),
        .in_id_illegal(1'b0), .in_id_pc(32'h0), .in_id_instr(32'h0),
        .in_id_rm_write(1'b0), .in_id_rm_idx(3'd0),
        .in_mem_dtlb_miss(1'b0), .in_mem_misaligned(1'b0),
        .in_mem_is_store(1'b0), .in_mem_pc(32'h0), .in_mem_addr(32'h0),
        .in_supervisor_mode(1'b0),
        .out_exception_vector(o2_vec), .out_fault_pc(o2_pc),
        .out_fault_addr(o2_addr), .out_additional_info(o2_info),
        .out_flush_if(o2_fif), .out_flush_id(o2_fid), .out_flush_ex(o2_fex),
        .out_busy(o2_busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        itlb = 0; illegal = 0; rm_write = 0; dtlb = 0; misal = 0; is_store = 0; sup = 0;
        if_pc = '0; id_pc = '0; id_instr = '0; mem_pc = '0; mem_addr = '0; rm_idx = '0;
    endtask

    // Reference of the response to the inputs currently applied.
    function automatic exp_t predict();
        exp_t e;
        exp_t r;
        r = '0;
        if (dtlb || misal) begin
            r.vec = dtlb ? 3'd3 : 3'd4;
            r.pc = mem_pc; r.addr = mem_addr; r.info = {31'b0, is_store}; r.fl = 3'b111;
        end else if (illegal) begin
            r.vec = 3'd2; r.pc = id_pc; r.info = id_instr; r.fl = 3'b011;
        end else if (rm_write && !sup) begin
            r.vec = 3'd5; r.pc = id_pc; r.info = {29'b0, rm_idx}; r.fl = 3'b011;
        end else if (itlb) begin
            r.vec = 3'd1; r.pc = if_pc; r.addr = if_pc; r.fl = 3'b001;
        end
        e = '0;
        if (reset) begin
            m_left = 0; m_mask = '0;
        end else if (m_left <= 1 && r.vec != 3'd0) begin
            e = r; e.busy = 1'b1; m_left = FC; m_mask = r.fl;
        end else if (m_left > 1) begin
            m_left = m_left - 1; e.fl = m_mask; e.busy = 1'b1;
        end else begin
            m_left = 0;
        end
        return e;
    endfunction

    // One clock: push the prediction, advance, pop and compare.
    task automatic step();
        exp_t e;
        q.push_back(predict());
        @(posedge clk);
        #1;
        if (q.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = q.pop_front();
            check("vector",    {29'b0, o_vec}, {29'b0, e.vec});
            check("fault_pc",  o_pc,   e.pc);
            check("fault_addr", o_addr, e.addr);
            check("info",      o_info, e.info);
            check("flush",     {29'b0, o_fex, o_fid, o_fif}, {29'b0, e.fl});
            check("busy",      {31'b0, o_busy}, {31'b0, e.busy});
        end
    endtask

    initial begin
        m_left = 0; m_mask = '0;
        reset = 1; clear_inputs();
        itlb2 = 0; if_pc2 = '0;
        dtlb = 1; misal = 1; illegal = 1; itlb = 1;   // reset must win over reports
        step(); step();
        check("reset_dut1_vec",  {29'b0, o2_vec}, 32'd0);
        check("reset_dut1_busy", {31'b0, o2_busy}, 32'd0);
        reset = 0; clear_inputs();
        step();

        // single dTLB store miss
        dtlb = 1; mem_pc = 32'h40; mem_addr = 32'h8004; is_store = 1;
        step(); clear_inputs();
        repeat (4) step();

        // simultaneous reports: misaligned is oldest
        itlb = 1; if_pc = 32'h50; illegal = 1; id_pc = 32'h4C; id_instr = 32'h1234;
        misal = 1; mem_pc = 32'h48; mem_addr = 32'h9001;
        step(); clear_inputs();
        repeat (5) step();

        // user-mode rm write, then the same in supervisor mode
        rm_write = 1; rm_idx = 3'd4; id_pc = 32'h80;
        step(); clear_inputs();
        repeat (4) step();
        rm_write = 1; rm_idx = 3'd4; id_pc = 32'h80; sup = 1;
        step(); clear_inputs();
        repeat (3) step();

        // reports during FLUSH: N+2 dropped, N+3 accepted
        illegal = 1; id_pc = 32'h60; id_instr = 32'h0BAD;
        step(); clear_inputs();                                    // now N+1
        step();                                                    // now N+2
        illegal = 1; id_pc = 32'h64; id_instr = 32'h1111; step();  // now N+3
        illegal = 1; id_pc = 32'h68; id_instr = 32'hFFFFFFFF; step();
        clear_inputs();
        repeat (4) step();

        // reset in the middle of a flush window
        dtlb = 1; mem_pc = 32'h90; mem_addr = 32'hA0;
        step(); clear_inputs();
        step();
        reset = 1; step();
        reset = 0;
        itlb = 1; if_pc = 32'hC0;
        step(); clear_inputs();
        repeat (4) step();

        // random mix
        for (int i = 0; i < 60; i++) begin
            clear_inputs();
            if ($urandom_range(0, 2) == 0) begin
                dtlb = $urandom_range(0, 3) == 0; misal = $urandom_range(0, 3) == 0;
                illegal = $urandom_range(0, 3) == 0; rm_write = $urandom_range(0, 2) == 0;
                itlb = $urandom_range(0, 1) == 1; sup = $urandom_range(0, 1) == 1;
                is_store = $urandom_range(0, 1) == 1; rm_idx = 3'($urandom_range(0, 7));
                if_pc = $urandom; id_pc = $urandom; mem_pc = $urandom;
                id_instr = $urandom; mem_addr = $urandom;
            end
            reset = ($urandom_range(0, 29) == 0);
            step();
        end
        reset = 0; clear_inputs();
        repeat (4) step();

        // FLUSH_CYCLES=1: consecutive fetch faults give adjacent pulses
        itlb2 = 1; if_pc2 = 32'h100;
        step();
        check("fc1_vec_a",  {29'b0, o2_vec}, 32'd1);
        check("fc1_pc_a",   o2_pc, 32'h100);
        check("fc1_addr_a", o2_addr, 32'h100);
        check("fc1_flush_a", {29'b0, o2_fex, o2_fid, o2_fif}, 32'd1);
        check("fc1_busy_a", {31'b0, o2_busy}, 32'd1);
        if_pc2 = 32'h104;
        step();
        check("fc1_vec_b",  {29'b0, o2_vec}, 32'd1);
        check("fc1_pc_b",   o2_pc, 32'h104);
        check("fc1_flush_b", {29'b0, o2_fex, o2_fid, o2_fif}, 32'd1);
        check("fc1_busy_b", {31'b0, o2_busy}, 32'd1);
        itlb2 = 0;
        step();
        check("fc1_vec_c",  {29'b0, o2_vec}, 32'd0);
        check("fc1_info_c", o2_info, 32'd0);
        check("fc1_flush_c", {29'b0, o2_fex, o2_fid, o2_fif}, 32'd0);
        check("fc1_busy_c", {31'b0, o2_busy}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
